image_line_feeder: RTL and testbench

Upstream feeder for `imageProcessTop`, the 3x3 kernel convolution stage. It moves one frame of pixels from a source stream into the convolution stage's pixel input (`i_data_valid`/`i_data`) under line-credit flow control. It preloads `PRELOAD_LINES` lines, then sends one further line per rising edge of the convolution stage's `o_intr` (line buffer freed). After the last image line it appends `PAD_LINES` all-zero lines to flush the line buffers.

---
 rtl/image_line_feeder.sv | 110 +++++++++++
 tb/tb_image_line_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_line_feeder.sv
// Line-credit feeder for the 3x3 convolution stage: preloads a few lines, then
// releases one line per line-free interrupt edge, and finally appends zero pad lines.
module image_line_feeder #(
    parameter int DATA_WIDTH    = 12,
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int PRELOAD_LINES = 4,
    parameter int PAD_LINES     = 2
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic                  s_pixel_valid,
    input  logic [DATA_WIDTH-1:0] s_pixel_data,
    output logic                  s_pixel_ready,
    input  logic                  i_intr,
    input  logic                  i_data_ready,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overflow
);

    localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LINE_MAX = (IMG_HEIGHT > PAD_LINES) ? IMG_HEIGHT : PAD_LINES;
    localparam int LINE_W   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam int CRED_W   = $clog2(PRELOAD_LINES + 1);

    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_IMG_LAST = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [LINE_W-1:0] LINE_PAD_LAST = LINE_W'(PAD_LINES - 1);
    localparam logic [CRED_W-1:0] CRED_MAX      = CRED_W'(PRELOAD_LINES);

    typedef enum logic [1:0] {IDLE, IMAGE, PAD, DONE} state_t;

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg;
    logic [LINE_W-1:0]   line_reg;
    logic [CRED_W-1:0]   credits_reg;
    logic                intr_d;

    logic running, has_credit, rise, issue, completion, last_line;

    always_comb begin
        state_next    = state_reg;
        running       = (state_reg == IMAGE) || (state_reg == PAD);
        has_credit    = (credits_reg != '0);
        rise          = i_intr & ~intr_d & running;
        s_pixel_ready = (state_reg == IMAGE) && has_credit && i_data_ready;
        issue         = has_credit && i_data_ready &&
                        (((state_reg == IMAGE) && s_pixel_valid) || (state_reg == PAD));
        completion    = issue && (col_reg == COL_LAST);
        last_line     = (state_reg == IMAGE) ? (line_reg == LINE_IMG_LAST)
                                             : (line_reg == LINE_PAD_LAST);
        busy          = (state_reg != IDLE);
        frame_done    = (state_reg == DONE);

        case (state_reg)
            IDLE:    if (start) state_next = IMAGE;
            IMAGE:   if (completion && last_line) state_next = PAD;
            PAD:     if (completion && last_line) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            line_reg     <= '0;
            credits_reg  <= '0;
            intr_d       <= 1'b0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_reg    <= state_next;
            intr_d       <= i_intr;
            o_data_valid <= issue;
            if (issue)
                o_data <= (state_reg == IMAGE) ? s_pixel_data : '0;

            if (state_reg == IDLE) begin
                if (start) begin
                    col_reg      <= '0;
                    line_reg     <= '0;
                    credits_reg  <= CRED_MAX;
                    err_overflow <= 1'b0;
                end
            end else if (running) begin
                if (issue)
                    col_reg <= completion ? '0 : col_reg + 1'b1;
                // The line counter restarts at the image/pad boundary to count pad lines.
                if (completion)
                    line_reg <= ((state_reg == IMAGE) && last_line) ? '0 : line_reg + 1'b1;
                if (rise && !completion) begin
                    if (credits_reg == CRED_MAX)
                        err_overflow <= 1'b1;
                    else
                        credits_reg <= credits_reg + 1'b1;
                end else if (!rise && completion) begin
                    credits_reg <= credits_reg - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_line_feeder.sv
// Bench for image_line_feeder: directed credit scenarios plus randomized frames,
// checked every cycle against a beat-index/credit-count reference model.
module tb_image_line_feeder;

    localparam int DW    = 12;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int PRE   = 4;
    localparam int PADL  = 2;
    localparam int TOTAL = (H + PADL) * W;

    logic          axi_clk = 1'b0;
    logic          axi_reset, start, s_pixel_valid, s_pixel_ready;
    logic [DW-1:0] s_pixel_data;
    logic          i_intr, i_data_ready, o_data_valid, busy, frame_done, err_overflow;
    logic [DW-1:0] o_data;

    image_line_feeder #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .PRELOAD_LINES(PRE), .PAD_LINES(PADL)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start),
        .s_pixel_valid(s_pixel_valid), .s_pixel_data(s_pixel_data),
        .s_pixel_ready(s_pixel_ready), .i_intr(i_intr), .i_data_ready(i_data_ready),
        .o_data_valid(o_data_valid), .o_data(o_data), .busy(busy),
        .frame_done(frame_done), .err_overflow(err_overflow)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position in frame as a flat beat index plus a credit count.
    int            m_phase = 0;      // 0 idle, 1 sending, 2 done cycle
    int            m_beat = 0;
    int            m_credits = 0;
    bit            m_intr_prev = 0;
    bit            m_err = 0;
    bit            m_ov = 0;
    logic [DW-1:0] m_od = '0;
    bit            armed = 0;
    bit            src_adv = 0;
    int            fr_beats = 0;
    int            frames = 0;
    logic [DW-1:0] last_img = '0;

    always @(negedge axi_clk) begin
        bit img, pad, iss, comp, rise, rdy;
        img  = (m_phase == 1) && (m_beat < H * W);
        pad  = (m_phase == 1) && (m_beat >= H * W);
        rdy  = img && (m_credits != 0) && i_data_ready;
        iss  = (m_credits != 0) && i_data_ready && ((img && s_pixel_valid) || pad);
        comp = iss && (m_beat % W == W - 1);
        rise = i_intr && !m_intr_prev && (m_phase == 1);

        if (armed) begin
            check("s_pixel_ready", s_pixel_ready, rdy);
            check("o_data_valid", o_data_valid, m_ov);
            check("o_data", o_data, m_od);
            check("busy", busy, m_phase != 0);
            check("frame_done", frame_done, m_phase == 2);
            check("err_overflow", err_overflow, m_err);
            if (o_data_valid) begin
                if (fr_beats < H * W) begin
                    if (fr_beats > 0) check("img_seq", o_data, DW'(last_img + 1'b1));
                    last_img = o_data;
                end else begin
                    check("pad_zero", o_data, 0);
                end
                fr_beats++;
            end
            if (frame_done) begin
                check("frame_beats", fr_beats, TOTAL);
                frames++;
            end
        end

        src_adv = rdy && s_pixel_valid && !axi_reset;
        if (axi_reset) begin
            m_phase = 0; m_beat = 0; m_credits = 0; m_intr_prev = 0;
            m_err = 0; m_ov = 0; m_od = '0; fr_beats = 0;
            armed = 1;
        end else begin
            m_intr_prev = i_intr;
            m_ov = iss;
            if (iss) m_od = img ? s_pixel_data : '0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1; m_beat = 0; m_credits = PRE; m_err = 0; fr_beats = 0;
                end
            end else if (m_phase == 1) begin
                if (iss) m_beat++;
                if (rise && !comp) begin
                    if (m_credits == PRE) m_err = 1;
                    else m_credits++;
                end else if (comp && !rise) begin
                    m_credits--;
                end
                if (m_beat == TOTAL) m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
        if (src_adv) s_pixel_data = s_pixel_data + 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1; tick();
        i_intr = 1'b0; tick();
    endtask

    task automatic start_frame();
        start = 1'b1; tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input bit rnd);
        int f0;
        f0 = frames;
        for (int c = 0; c < 3000 && frames == f0; c++) begin
            if (rnd) begin
                s_pixel_valid = ($urandom % 4) != 0;
                i_data_ready  = ($urandom % 4) != 0;
                i_intr        = ($urandom % 6) == 0;
                start         = ($urandom % 50) == 0;
            end else begin
                i_intr = (c % 12) == 0;
            end
            tick();
        end
        check("frame_finished", frames != f0, 1);
        s_pixel_valid = 1'b1; i_data_ready = 1'b1; i_intr = 1'b0; start = 1'b0;
    endtask

    initial begin
        axi_reset = 1'b1; start = 1'b0; s_pixel_valid = 1'b1; s_pixel_data = 1;
        i_intr = 1'b0; i_data_ready = 1'b1;
        wait_cycles(3);
        axi_reset = 1'b0;
        tick();
        check("rst_valid", o_data_valid, 0);
        check("rst_busy", busy, 0);
        pulse_intr();
        pulse_intr();
        check("idle_intr_busy", busy, 0);

        // Preload: four lines then stall for credits
        start_frame();
        wait_cycles(50);
        $display("preload beats=%0d busy=%0b", fr_beats, busy);
        check("preload_beats", fr_beats, PRE * W);
        check("stall_ready", s_pixel_ready, 0);
        check("stall_busy", busy, 1);

        pulse_intr();
        pulse_intr();
        wait_cycles(30);
        check("two_credits", fr_beats, 48);
        pulse_intr();
        wait_cycles(20);
        check("pad_line1", fr_beats, 56);
        pulse_intr();
        wait_cycles(20);
        $display("frame1 frames=%0d busy=%0b", frames, busy);
        check("frame1_done", frames, 1);
        check("frame1_idle", busy, 0);

        // Held interrupt counts once; rise on a completion keeps credits level
        start_frame();
        wait_cycles(50);
        i_intr = 1'b1; wait_cycles(5); i_intr = 1'b0;
        wait_cycles(20);
        check("held_intr", fr_beats, 40);
        check("held_no_err", err_overflow, 0);
        i_intr = 1'b1; tick(); i_intr = 1'b0;
        wait_cycles(7);
        i_intr = 1'b1; tick(); i_intr = 1'b0;
        wait_cycles(20);
        check("rise_on_completion", fr_beats, 56);
        pulse_intr();
        wait_cycles(20);
        $display("frame2 frames=%0d", frames);
        check("frame2_done", frames, 2);

        // Overflow at full credits, cleared by the next start
        start_frame();
        pulse_intr();
        check("overflow_set", err_overflow, 1);
        finish_frame(1'b0);
        start_frame();
        tick();
        check("overflow_clear", err_overflow, 0);

        // Reset in the middle of line 2, then a fresh randomized frame
        for (int c = 0; c < 100 && fr_beats != 2 * W + 3; c++) tick();
        check("reached_mid_line", fr_beats, 2 * W + 3);
        axi_reset = 1'b1; tick(); axi_reset = 1'b0;
        check("mid_rst_valid", o_data_valid, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        start_frame();
        finish_frame(1'b1);
        $display("post-reset frame frames=%0d", frames);

        for (int f = 0; f < 3; f++) begin
            tick();
            start_frame();
            finish_frame(1'b1);
            $display("random frame %0d frames=%0d", f, frames);
        end
        wait_cycles(3);
        check("frame_count", frames, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
